mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single-port word memory (`mem`) on behalf of the `rv` core.
- Arbitrates between two requesters, instruction fetch (IF) and data load/store (D), and serialises them onto one memory port.
- Performs sub-word load extraction with sign/zero extension, and sub-word stores as read-modify-write.
- Memory is always written as full aligned words; mem_b and mem_h are tied 0.

Parameters:
- ADDR_W, 32, byte-address width of requester and memory addresses.
- RESET_PRIO_D, 1, requester favoured by the first arbitration after reset (1 = D, 0 = IF).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle when high together with valid
- if_addr  in  ADDR_W  fetch byte address
- if_rsp_valid  out  1  one-cycle fetch response pulse
- if_rsp_data  out  32  fetched word
- if_rsp_err  out  1  misaligned fetch
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle when high together with valid
- d_addr  in  ADDR_W  data byte address
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 byte, 1 half, 2 word; 3 is illegal
- d_unsigned  in  1  zero-extend load (LBU/LHU)
- d_wdata  in  32  store data, right-aligned
- d_rsp_valid  out  1  one-cycle data response pulse
- d_rsp_data  out  32  extended load data; 0 for stores
- d_rsp_err  out  1  misaligned access or illegal size
- mem_addr  out  ADDR_W  word-aligned byte address: {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  merged write word
- mem_write  out  1  write strobe, combinational from state
- mem_b, mem_h  out  1  constant 0
- mem_rdata  in  32  combinational read data for mem_addr

Behaviour:
- **State machine:** IDLE, ACCESS, WRITE, RESP.
- **Reset:**
  - rst sampled high forces IDLE and clears the captured request and response registers.
  - All outputs read 0 in the cycle after the reset edge, except ready, which follows IDLE rules.
  - A request in flight during reset is dropped: no write is issued and no response is produced.
- **Request handshake:**
  - Ready is high only in IDLE, and only for the requester the arbiter grants.
  - A request is accepted at the edge where valid && ready.
  - Requests are captured into registers at acceptance; requester inputs are ignored afterwards.
- **Arbitration:**
  - Round-robin. If both requesters are valid in IDLE, the one not granted last wins.
  - last_grant is initialised by RESET_PRIO_D.
  - A single valid requester is granted immediately.
- **Alignment check at acceptance:**
  - Error cases: half with addr[0] = 1; word or fetch with addr[1:0] != 0; d_size = 3.
  - An erroring request goes IDLE -> RESP with err = 1 and data = 0, and never touches memory (mem_write stays 0).
- **ACCESS state (mem_addr = captured word address):**
  - Fetch or load: capture mem_rdata, then go to RESP.
  - Word store: mem_write = 1, mem_wdata = d_wdata, then go to RESP.
  - Byte or half store: capture mem_rdata, then go to WRITE.
- **WRITE state:**
  - mem_write = 1.
  - mem_wdata = captured word with the addressed lane(s) replaced: byte lane = addr[1:0], half lane = addr[1].
  - Then go to RESP.
- **RESP state:**
  - The owner's rsp_valid is high for exactly one cycle.
  - The other requester's rsp_valid stays 0.
  - Next state is IDLE.
- **Load extraction:**
  - Byte: data = rdata[8*addr[1:0] +: 8].
  - Half: data = rdata[16*addr[1] +: 16].
  - Sign-extend unless d_unsigned; d_unsigned is ignored for word loads.
- **Latency from the accept edge T:**
  - Fetch, load or word store: rsp_valid in cycle T+2.
  - Sub-word store: rsp_valid in cycle T+3.
  - Error: rsp_valid in cycle T+1.
  - Accepts occur no more often than once every 3 cycles (2 for errors).
- **mem_addr:** held at the captured address in ACCESS, WRITE and RESP; 0 in IDLE.
- **Response data:** rsp_data and rsp_err are valid only while rsp_valid is high, and are 0 otherwise.

Decomposition:
- **Package rv_mem_pkg:**
  - size enum: MEM_B = 0, MEM_H = 1, MEM_W = 2.
  - arbiter state enum.
  - owner enum: OWN_IF, OWN_D.
  - Constant WORD_BYTES = 4.
- **Sub-module mem_lane (combinational):**
  - Inputs: addr[1:0], size, unsigned, old word, store data.
  - Outputs: merged store word, extended load value, misalign flag.
  - Instantiated once in mem_arbiter.

Test Plan:
- **Fetch:** mem word 0x40 = 0x00500093; fetch 0x40 accepted at T -> if_rsp_valid at T+2, data 0x00500093, err 0, mem_write never 1.
- **Byte loads:** word 0x100 = 0x80FF7F01.
  - LB 0x102 -> 0xFFFFFFFF.
  - LBU 0x103 -> 0x00000080.
  - LH 0x102 -> 0xFFFF80FF.
- **Byte store RMW:** word 0x200 = 0x11223344; SB 0x201 with data 0xAB -> ACCESS read, mem_write 1 in cycle T+2 with mem_wdata 0x1122AB44, d_rsp_valid at T+3.
- **Round-robin with simultaneous requests:** both requesters valid continuously from reset (RESET_PRIO_D = 1) -> grant order D, IF, D, IF, with accepts spaced 3 cycles apart and no response on the wrong port.
- **Misalignment:** SW to 0x302 and LH from 0x301 -> d_rsp_err 1 at T+1, data 0, mem_write stays 0, memory unchanged.
- **Reset mid-operation:** rst asserted during WRITE of SB 0x201 -> memory word unchanged, no d_rsp_valid, IDLE next cycle, new fetch then serviced normally.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared types for the rv core memory arbiter.
//   size_e  : access size encoding on the data request port (3 is illegal)
//   state_e : arbiter sequencing states
//   owner_e : which requester owns the transaction in flight
//   req_t   : request fields captured at acceptance
package rv_mem_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    owner_e      owner;
    logic        we;
    logic [1:0]  size;
    logic        zext;
    logic        err;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane.sv
// Byte-lane steering for sub-word memory accesses (purely combinational).
//   addr       : byte offset within the word
//   size       : access size (MEM_B / MEM_H / MEM_W, 3 illegal)
//   zext       : zero-extend loads instead of sign-extending
//   old_word   : word currently held in memory
//   store_data : right-aligned store data
//   merged     : old_word with the addressed lane(s) replaced by store_data
//   load_value : addressed lane(s) of old_word, extended to 32 bits
//   misalign   : access is misaligned for its size, or size is illegal
module mem_lane
  import rv_mem_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  output logic [31:0] merged,
  output logic [31:0] load_value,
  output logic        misalign
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    merged     = old_word;
    load_value = old_word;
    misalign   = 1'b0;
    lane_b     = old_word[8*addr +: 8];
    lane_h     = old_word[16*addr[1] +: 16];
    case (size)
      MEM_B: begin
        merged[8*addr +: 8] = store_data[7:0];
        load_value          = {{24{~zext & lane_b[7]}}, lane_b};
      end
      MEM_H: begin
        misalign                 = addr[0];
        merged[16*addr[1] +: 16] = store_data[15:0];
        load_value               = {{16{~zext & lane_h[15]}}, lane_h};
      end
      MEM_W: begin
        misalign = |addr;
        merged   = store_data;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sequencing instruction-fetch (IF) and data (D) requests
// onto a single-port word memory, with sub-word loads and read-modify-write
// sub-word stores.
//   clk, rst              : clock, synchronous active-high reset
//   if_req_* / if_addr    : fetch request handshake and byte address
//   if_rsp_*              : one-cycle fetch response (data, misalign error)
//   d_req_* / d_addr ...  : data request handshake, address, we, size, unsigned, wdata
//   d_rsp_*               : one-cycle data response (extended load data, error)
//   mem_*                 : word-aligned memory port; mem_b / mem_h tied 0
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter bit RESET_PRIO_D = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [31:0]       d_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_write,
  output logic              mem_b,
  output logic              mem_h,
  input  logic [31:0]       mem_rdata
);

  state_e            state, state_next;
  owner_e            last_grant;
  req_t              cap;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       cap_rdata;

  logic        idle, grant_d, grant_if, accept, resp;
  logic [1:0]  lane_addr, lane_size;
  logic        lane_zext;
  logic [31:0] lane_merged, lane_load;
  logic        lane_misalign;

  assign mem_b = 1'b0;
  assign mem_h = 1'b0;

  // Requester that lost the previous arbitration wins a tie.
  assign idle     = (state == ST_IDLE);
  assign grant_d  = d_req_valid && (!if_req_valid || last_grant == OWN_IF);
  assign grant_if = if_req_valid && !grant_d;
  assign accept   = idle && (grant_d || grant_if);

  // In IDLE the lane checks the live request being granted; afterwards it
  // works on the captured request for merge and extraction.
  always_comb begin
    lane_addr = cap_addr[1:0];
    lane_size = cap.size;
    lane_zext = cap.zext;
    if (idle) begin
      lane_addr = grant_d ? d_addr[1:0] : if_addr[1:0];
      lane_size = grant_d ? d_size : MEM_W;
      lane_zext = grant_d && d_unsigned;
    end
  end

  mem_lane u_lane (
    .addr       (lane_addr),
    .size       (lane_size),
    .zext       (lane_zext),
    .old_word   (cap_rdata),
    .store_data (cap.wdata),
    .merged     (lane_merged),
    .load_value (lane_load),
    .misalign   (lane_misalign)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      // NOTE: captured request and read data are cleared too, so a dropped transaction leaves no residue.
      state      <= ST_IDLE;
      last_grant <= RESET_PRIO_D ? OWN_IF : OWN_D;
      cap        <= '0;
      cap_addr   <= '0;
      cap_rdata  <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= grant_d ? OWN_D : OWN_IF;
        cap.owner  <= grant_d ? OWN_D : OWN_IF;
        cap.we     <= grant_d && d_we;
        cap.size   <= grant_d ? d_size : MEM_W;
        cap.zext   <= grant_d && d_unsigned;
        cap.err    <= lane_misalign;
        cap.wdata  <= grant_d ? d_wdata : 32'd0;
        cap_addr   <= grant_d ? d_addr : if_addr;
      end
      if (state == ST_ACCESS) cap_rdata <= mem_rdata;
    end
  end

  always_comb begin
    state_next   = state;
    if_req_ready = 1'b0;
    d_req_ready  = 1'b0;
    mem_write    = 1'b0;
    case (state)
      ST_IDLE: begin
        if_req_ready = grant_if;
        d_req_ready  = grant_d;
        if (accept) state_next = lane_misalign ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cap.we && cap.size == MEM_W) begin
          mem_write  = 1'b1;
          state_next = ST_RESP;
        end else if (cap.we) begin
          state_next = ST_WRITE;
        end else begin
          state_next = ST_RESP;
        end
      end
      ST_WRITE: begin
        mem_write  = 1'b1;
        state_next = ST_RESP;
      end
      default: state_next = ST_IDLE;
    endcase
    // A transaction caught by reset must not reach memory or respond.
    if (rst) mem_write = 1'b0;
  end

  assign mem_wdata = mem_write ? lane_merged : 32'd0;
  assign mem_addr  = idle ? '0 : {cap_addr[ADDR_W-1:2], 2'b00};

  assign resp         = (state == ST_RESP) && !rst;
  assign if_rsp_valid = resp && (cap.owner == OWN_IF);
  assign d_rsp_valid  = resp && (cap.owner == OWN_D);
  assign if_rsp_err   = if_rsp_valid && cap.err;
  assign d_rsp_err    = d_rsp_valid && cap.err;
  assign if_rsp_data  = (if_rsp_valid && !cap.err) ? lane_load : 32'd0;
  assign d_rsp_data   = (d_rsp_valid && !cap.err && !cap.we) ? lane_load : 32'd0;

endmodule
